circuit1_hlsm: RTL and testbench

Multi-cycle, resource-shared implementation of the circuit1 dataflow. It computes `z = (a+b > a+c) ? a+b : a+c` and `x = a*c - (a+b)` using one shared add/sub/compare unit and one multiplier, sequenced by a high-level state machine with a Start/Done handshake. It replaces the fully parallel circuit1 netlist wherever area matters more than latency. It sits directly under the top-level HLS wrapper.

---
 rtl/circuit1_pkg.sv | 22 ++
 rtl/circuit1_alu.sv | 32 +++
 rtl/circuit1_hlsm.sv | 131 +++++++++++++
 tb/tb_circuit1_hlsm.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/circuit1_pkg.sv
// Shared types and default widths for the resource-shared circuit1 datapath.
package circuit1_pkg;

  localparam int DEF_IN_WIDTH  = 8;
  localparam int DEF_OUT_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_WAIT  = 3'd0,
    ST_S1    = 3'd1,
    ST_S2    = 3'd2,
    ST_S3    = 3'd3,
    ST_S4    = 3'd4,
    ST_FINAL = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_CMP = 2'd2
  } alu_op_e;

endpackage

// File: rtl/circuit1_alu.sv
// Shared add/subtract/compare unit; the compare result is the borrow of a
// dedicated subtract path so that compare and subtract can share one cycle.
import circuit1_pkg::*;

module circuit1_alu #(
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
  input  alu_op_e                op,
  input  logic [OUT_WIDTH-1:0]   op_a,
  input  logic [OUT_WIDTH-1:0]   op_b,
  input  logic [OUT_WIDTH-1:0]   cmp_a,
  input  logic [OUT_WIDTH-1:0]   cmp_b,
  output logic [OUT_WIDTH-1:0]   result,
  output logic                   gt
);

  logic [OUT_WIDTH:0] cmp_diff;

  always_comb begin
    // cmp_b - cmp_a borrows exactly when cmp_a > cmp_b
    cmp_diff = {1'b0, cmp_b} - {1'b0, cmp_a};
    gt       = cmp_diff[OUT_WIDTH];
    result   = '0;
    case (op)
      ALU_ADD: result = op_a + op_b;
      ALU_SUB: result = op_a - op_b;
      ALU_CMP: result = {{(OUT_WIDTH-1){1'b0}}, gt};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/circuit1_hlsm.sv
// Multi-cycle circuit1: z = max(a+b, a+c), x = a*c - (a+b), sequenced by an
// HLSM around one shared ALU and one multiplier with a Start/Done handshake.
import circuit1_pkg::*;

module circuit1_hlsm #(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Start,
  input  logic [IN_WIDTH-1:0]  a,
  input  logic [IN_WIDTH-1:0]  b,
  input  logic [IN_WIDTH-1:0]  c,
  output logic [IN_WIDTH-1:0]  z,
  output logic [OUT_WIDTH-1:0] x,
  output logic                 Done
);

  state_e                 state_q, state_d;
  logic [IN_WIDTH-1:0]    ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
  logic [IN_WIDTH-1:0]    d_q, d_d, e_q, e_d;
  logic [OUT_WIDTH-1:0]   f_q, f_d, xw_q, xw_d;
  logic                   g_q, g_d;
  logic [IN_WIDTH-1:0]    z_q, z_d;
  logic [OUT_WIDTH-1:0]   x_q, x_d;

  alu_op_e                alu_op;
  logic [OUT_WIDTH-1:0]   alu_a, alu_b, alu_result;
  logic                   alu_gt;
  logic [2*IN_WIDTH-1:0]  prod;

  assign prod = {{IN_WIDTH{1'b0}}, ra_q} * {{IN_WIDTH{1'b0}}, rc_q};

  circuit1_alu #(.OUT_WIDTH(OUT_WIDTH)) u_alu (
    .op     (alu_op),
    .op_a   (alu_a),
    .op_b   (alu_b),
    .cmp_a  (OUT_WIDTH'(d_q)),
    .cmp_b  (OUT_WIDTH'(e_q)),
    .result (alu_result),
    .gt     (alu_gt)
  );

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rc_d    = rc_q;
    d_d     = d_q;
    e_d     = e_q;
    f_d     = f_q;
    g_d     = g_q;
    xw_d    = xw_q;
    z_d     = z_q;
    x_d     = x_q;
    alu_op  = ALU_ADD;
    alu_a   = OUT_WIDTH'(ra_q);
    alu_b   = OUT_WIDTH'(rb_q);

    case (state_q)
      ST_WAIT: begin
        if (Start) begin
          ra_d    = a;
          rb_d    = b;
          rc_d    = c;
          state_d = ST_S1;
        end
      end
      ST_S1: begin
        d_d     = IN_WIDTH'(alu_result);
        state_d = ST_S2;
      end
      ST_S2: begin
        alu_b   = OUT_WIDTH'(rc_q);
        e_d     = IN_WIDTH'(alu_result);
        f_d     = OUT_WIDTH'(prod);
        state_d = ST_S3;
      end
      ST_S3: begin
        // subtract and compare share this cycle via the ALU's two diff paths
        alu_op  = ALU_SUB;
        alu_a   = f_q;
        alu_b   = OUT_WIDTH'(d_q);
        xw_d    = alu_result;
        g_d     = alu_gt;
        state_d = ST_S4;
      end
      ST_S4: begin
        z_d     = g_q ? d_q : e_q;
        x_d     = xw_q;
        state_d = ST_FINAL;
      end
      ST_FINAL: state_d = ST_WAIT;
      default:  state_d = ST_WAIT;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_WAIT;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
      d_q     <= '0;
      e_q     <= '0;
      f_q     <= '0;
      g_q     <= 1'b0;
      xw_q    <= '0;
      z_q     <= '0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rc_q    <= rc_d;
      d_q     <= d_d;
      e_q     <= e_d;
      f_q     <= f_d;
      g_q     <= g_d;
      xw_q    <= xw_d;
      z_q     <= z_d;
      x_q     <= x_d;
    end
  end

  assign z    = z_q;
  assign x    = x_q;
  assign Done = (state_q == ST_FINAL);

endmodule

// File: tb/tb_circuit1_hlsm.sv
// Scoreboard bench for circuit1_hlsm: expected z/x are queued at each accepted
// Start and checked when Done pulses, alongside latency and reset behaviour.
module tb_circuit1_hlsm;

  typedef struct {
    logic [7:0]  z;
    logic [15:0] x;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start;
  logic [7:0]  a, b, c;
  logic [7:0]  z;
  logic [15:0] x;
  logic        Done;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_count = 0;
  int   done_cycs[$];
  exp_t sb[$];
  exp_t mon_exp;
  logic done_prev = 1'b0;

  circuit1_hlsm #(.IN_WIDTH(8), .OUT_WIDTH(16)) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .Start (Start),
    .a     (a),
    .b     (b),
    .c     (c),
    .z     (z),
    .x     (x),
    .Done  (Done)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc++;

  function automatic exp_t model(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] ic);
    exp_t        r;
    logic [7:0]  dd, ee;
    logic [15:0] ff;
    dd  = ia + ib;
    ee  = ia + ic;
    ff  = {8'h00, ia} * {8'h00, ic};
    r.z = (dd > ee) ? dd : ee;
    r.x = ff - {8'h00, dd};
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Done is a one-cycle pulse; each pulse retires the oldest queued expectation
  always @(negedge Clk) begin
    if (Done === 1'b1) begin
      done_count++;
      done_cycs.push_back(cyc);
      checkOutput("done_single_cycle", {31'd0, done_prev}, 32'd0);
      checkOutput("done_expected", (sb.size() != 0) ? 32'd1 : 32'd0, 32'd1);
      if (sb.size() != 0) begin
        mon_exp = sb.pop_front();
        checkOutput("z", {24'd0, z}, {24'd0, mon_exp.z});
        checkOutput("x", {16'd0, x}, {16'd0, mon_exp.x});
      end
    end
    done_prev = Done;
  end

  task automatic applyStimulus(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] ic);
    int accept_cyc;
    int start_count;
    int waited;
    @(negedge Clk);
    a = ia;
    b = ib;
    c = ic;
    Start = 1'b1;
    sb.push_back(model(ia, ib, ic));
    accept_cyc = cyc + 1;
    start_count = done_count;
    @(negedge Clk);
    Start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    c = 8'($urandom);
    waited = 0;
    while (done_count == start_count && waited < 20) begin
      @(negedge Clk);
      #1;
      waited++;
    end
    checkOutput("done_timeout", (done_count != start_count) ? 32'd1 : 32'd0, 32'd1);
    // Done appears four edges after the accepting edge (five counting it)
    if (done_count != start_count)
      checkOutput("latency", 32'(done_cycs[$] - accept_cyc), 32'd4);
  endtask

  initial begin
    int base_cyc;
    int count_before;
    int n;

    Rst = 1'b1;
    Start = 1'b0;
    a = '0;
    b = '0;
    c = '0;
    repeat (2) @(negedge Clk);
    checkOutput("reset_z", {24'd0, z}, 32'd0);
    checkOutput("reset_x", {16'd0, x}, 32'd0);
    checkOutput("reset_done", {31'd0, Done}, 32'd0);
    Rst = 1'b0;

    applyStimulus(8'd10, 8'd20, 8'd5);
    applyStimulus(8'd200, 8'd100, 8'd50);
    applyStimulus(8'd2, 8'd10, 8'd0);
    applyStimulus(8'd1, 8'd255, 8'd1);
    applyStimulus(8'd0, 8'd0, 8'd0);
    applyStimulus(8'd255, 8'd255, 8'd255);

    // Start held high with fresh inputs every cycle: accepts only every 6th edge
    @(negedge Clk);
    count_before = done_count;
    n = done_cycs.size();
    base_cyc = cyc + 1;
    for (int k = 0; k < 18; k++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      c = 8'($urandom);
      Start = 1'b1;
      if (k % 6 == 0) sb.push_back(model(a, b, c));
      @(negedge Clk);
    end
    Start = 1'b0;
    repeat (6) @(negedge Clk);
    #1;
    checkOutput("held_done_count", 32'(done_count - count_before), 32'd3);
    if (done_cycs.size() >= n + 3) begin
      checkOutput("held_done0", 32'(done_cycs[n] - base_cyc), 32'd4);
      checkOutput("held_done1", 32'(done_cycs[n+1] - base_cyc), 32'd10);
      checkOutput("held_done2", 32'(done_cycs[n+2] - base_cyc), 32'd16);
    end

    // Abort a run in S3; no expectation is queued, so any Done is flagged
    @(negedge Clk);
    a = 8'd10;
    b = 8'd20;
    c = 8'd5;
    Start = 1'b1;
    count_before = done_count;
    @(negedge Clk);
    Start = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    checkOutput("abort_z", {24'd0, z}, 32'd0);
    checkOutput("abort_x", {16'd0, x}, 32'd0);
    checkOutput("abort_done", {31'd0, Done}, 32'd0);
    repeat (8) @(negedge Clk);
    #1;
    checkOutput("abort_no_done", 32'(done_count - count_before), 32'd0);

    applyStimulus(8'd10, 8'd20, 8'd5);

    repeat (3) @(negedge Clk);
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule
